// File: rtl/out_pins_uart_tx.sv
// Reports every change of the CPU out_pins value to the host as one ASCII character
// ('0'+value) sent as an 8N1 UART frame, with a small FIFO to absorb bursts.
module out_pins_uart_tx #(
    parameter int REGISTER_WIDTH             = 4,
    parameter int UART_DATA_LENGTH           = 8,
    parameter int BAUD_COUNTS_PER_BIT        = 521,
    parameter int BAUD_RATE_COUNTER_BITWIDTH = 10,
    parameter int FIFO_DEPTH                 = 4,
    parameter int FIFO_ADDR_WIDTH            = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [REGISTER_WIDTH-1:0] out_pins_i,
    input  logic                      enable_i,
    output logic                      tx_o,
    output logic                      busy_o,
    output logic                      overflow_o
);

    localparam int BIT_W = $clog2(UART_DATA_LENGTH);
    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                                  state;
    logic [BAUD_RATE_COUNTER_BITWIDTH-1:0]   baud_cnt;
    logic [BIT_W-1:0]                        bit_cnt;
    logic [UART_DATA_LENGTH-1:0]             shift_q;
    logic [REGISTER_WIDTH-1:0]               prev_q;

    logic [UART_DATA_LENGTH-1:0]             fifo_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]              wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                        fifo_count;

    logic baud_end, fifo_empty, fifo_full, push, push_ok, pop, line_bit;
    logic [UART_DATA_LENGTH-1:0] push_byte;

    assign baud_end   = (baud_cnt == BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push       = enable_i && (out_pins_i != prev_q);
    assign push_byte  = {(UART_DATA_LENGTH - REGISTER_WIDTH)'(4'b0011), out_pins_i};

    // The FSM takes a byte either from idle or straight out of the stop bit.
    assign pop     = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!fifo_full || pop);

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_q[0];
            default: line_bit = 1'b1;
        endcase
    end

    // Tracks the input even while disabled so re-enabling never reports a stale change.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) prev_q <= '0;
        else          prev_q <= out_pins_i;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !push_ok) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
        end else begin
            tx_o   <= line_bit;
            busy_o <= (state != IDLE) || !fifo_empty;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr];
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift_q  <= shift_q >> 1;
                        if (bit_cnt == BIT_W'(UART_DATA_LENGTH - 1)) state <= STOP;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_q <= fifo_mem[rd_ptr];
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_pins_uart_tx.sv
// Directed bench for out_pins_uart_tx: a UART monitor decodes tx_o and checks each
// frame against a queue of expected characters filled as changes are driven.
module tb_out_pins_uart_tx;

    localparam int B = 16;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [3:0] out_pins_i;
    logic       enable_i;
    logic       tx_o, busy_o, overflow_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nrx = 0;
    logic [7:0] exp_q [$];
    int starts [$];

    out_pins_uart_tx #(
        .REGISTER_WIDTH(4), .UART_DATA_LENGTH(8), .BAUD_COUNTS_PER_BIT(B),
        .BAUD_RATE_COUNTER_BITWIDTH(10), .FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .out_pins_i(out_pins_i), .enable_i(enable_i),
        .tx_o(tx_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        int i;
        repeat (2) tick();
        for (i = 0; i < maxc && busy_o !== 1'b0; i++) tick();
        chk("wait_idle", busy_o, 1'b0);
        repeat (2) tick();
    endtask

    // UART monitor: samples mid-bit, aborts the frame if reset is seen.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (reset_i === 1'b1 && tx_o === 1'b0) begin
                int start_c;
                bit abort;
                logic [7:0] rx;
                start_c = cyc;
                abort = 1'b0;
                rx = '0;
                for (int c = 1; c <= 9 * B + B / 2; c++) begin
                    @(posedge clk_i);
                    #1;
                    if (reset_i !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (c % B == B / 2) begin
                        if (c / B == 0)      chk("start_bit", tx_o, 1'b0);
                        else if (c / B <= 8) rx[c / B - 1] = tx_o;
                        else                 chk("stop_bit", tx_o, 1'b1);
                    end
                end
                if (!abort) begin
                    starts.push_back(start_c);
                    nrx++;
                    if (exp_q.size() == 0) chk("unexpected_frame", {24'h0, rx}, 32'hFFFF_FFFF);
                    else                   chk("rx_byte", {24'h0, rx}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit bad;
        reset_i = 1'b0;
        enable_i = 1'b1;
        out_pins_i = 4'h0;
        repeat (3) tick();
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
        reset_i = 1'b1;

        // Idle: nothing moves with a stable zero input
        bad = 1'b0;
        repeat (2000) begin
            tick();
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || overflow_o !== 1'b0) bad = 1'b1;
        end
        chk("idle_quiet", {31'h0, bad}, 32'h0);
        chk("idle_nrx", nrx, 0);

        // Single character 0x35 with exact frame timing
        out_pins_i = 4'h5;
        exp_q.push_back(8'h35);
        tick();
        chk("lat_n_tx", tx_o, 1'b1);
        chk("lat_n_busy", busy_o, 1'b0);
        tick();
        chk("lat_n1_tx", tx_o, 1'b1);
        chk("lat_n1_busy", busy_o, 1'b1);
        tick();
        chk("lat_n2_tx", tx_o, 1'b0);
        repeat (9 * B - 1) tick();
        chk("last_data_bit", tx_o, 1'b0);
        tick();
        chk("stop_begin", tx_o, 1'b1);
        repeat (B - 1) tick();
        chk("busy_end_stop", busy_o, 1'b1);
        tick();
        chk("busy_drop", busy_o, 1'b0);
        wait_idle(100);
        chk("single_nrx", nrx, 1);

        // Burst 1..6: 1 in flight, 2..5 queued, 6 dropped
        enable_i = 1'b0;
        out_pins_i = 4'h0;
        tick();
        enable_i = 1'b1;
        tick();
        starts.delete();
        n0 = nrx;
        for (int v = 1; v <= 6; v++) begin
            out_pins_i = 4'(v);
            if (v <= 5) exp_q.push_back(8'h30 + 8'(v));
            tick();
        end
        tick();
        chk("burst_ovf", overflow_o, 1'b1);
        wait_idle(60 * B + 50);
        chk("burst_nrx", nrx - n0, 5);
        if (starts.size() == 5) chk("burst_b2b", starts[4] - starts[0], 40 * B);
        else                    chk("burst_starts", starts.size(), 5);
        chk("burst_ovf_sticky", overflow_o, 1'b1);

        // Enable gating: changes while disabled are never reported
        n0 = nrx;
        enable_i = 1'b0;
        out_pins_i = 4'h9;
        tick();
        out_pins_i = 4'h3;
        tick();
        enable_i = 1'b1;
        repeat (3 * B) tick();
        chk("en_busy", busy_o, 1'b0);
        chk("en_nrx", nrx - n0, 0);
        out_pins_i = 4'h7;
        exp_q.push_back(8'h37);
        tick();
        wait_idle(12 * B);
        chk("en_nrx_after", nrx - n0, 1);

        // Reset during data bit 3, then the held 7 is reported once
        n0 = nrx;
        out_pins_i = 4'h2;
        exp_q.push_back(8'h32);
        tick();
        repeat (1 + 4 * B + B / 2) tick();
        reset_i = 1'b0;
        #1;
        chk("midrst_tx", tx_o, 1'b1);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_ovf", overflow_o, 1'b0);
        exp_q.delete();
        out_pins_i = 4'h7;
        repeat (3) tick();
        exp_q.push_back(8'h37);
        reset_i = 1'b1;
        wait_idle(12 * B);
        repeat (3 * B) tick();
        chk("midrst_nrx", nrx - n0, 1);

        // Full FIFO with a push landing on the same edge the stop bit pops
        n0 = nrx;
        for (int v = 8; v <= 12; v++) begin
            out_pins_i = 4'(v);
            exp_q.push_back(8'h30 + 8'(v));
            tick();
        end
        repeat (10 * B - 4) tick();
        out_pins_i = 4'hD;
        exp_q.push_back(8'h3D);
        tick();
        tick();
        chk("fullpop_ovf", overflow_o, 1'b0);
        wait_idle(70 * B);
        chk("fullpop_ovf_end", overflow_o, 1'b0);
        chk("fullpop_nrx", nrx - n0, 6);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
